// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM period / high-time measurement block.
package pwm_pkg;

  localparam int CW_DEFAULT = 7;
  localparam int CNT_MAX    = (1 << CW_DEFAULT) - 1;

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    TIMEOUT   = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings the asynchronous PWM input into the clk domain and flags its rising edges.
module pwm_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s2,
  output logic rise
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2   = s2_q;
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/pwm_meas.sv
// Measures period and high time of a PWM input in clk cycles and flags loss of signal.
module pwm_meas
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in,
  output logic [CW-1:0] high_out,
  output logic [CW-1:0] period_out,
  output logic          valid,
  output logic          lost,
  output pwm_state_e    dbg_state_o
);

  localparam logic [CW-1:0] SAT  = '1;
  localparam logic [CW-1:0] ZERO = '0;
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic s2, rise;

  pwm_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s2     (s2),
    .rise   (rise)
  );

  pwm_state_e    state_q, state_d;
  logic [CW-1:0] period_cnt_q, period_cnt_d;
  logic [CW-1:0] high_cnt_q, high_cnt_d;
  logic [CW-1:0] high_out_q, high_out_d;
  logic [CW-1:0] period_out_q, period_out_d;
  logic          valid_q, valid_d;
  logic          lost_q, lost_d;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == SAT) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_EDGE;
      period_cnt_q <= ZERO;
      high_cnt_q   <= ZERO;
      high_out_q   <= ZERO;
      period_out_q <= ZERO;
      valid_q      <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      high_out_q   <= high_out_d;
      period_out_q <= period_out_d;
      valid_q      <= valid_d;
      lost_q       <= lost_d;
    end
  end

  // valid is a one-cycle strobe with no back-pressure: the consumer must capture
  // high_out/period_out in the cycle valid is high; they hold until the next update.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    high_out_d   = high_out_q;
    period_out_d = period_out_q;
    valid_d      = 1'b0;
    lost_d       = lost_q;
    case (state_q)
      WAIT_EDGE: begin
        period_cnt_d = ZERO;
        high_cnt_d   = ZERO;
        if (rise) begin
          state_d      = MEASURE;
          period_cnt_d = ONE;
          high_cnt_d   = ONE;
        end
      end
      MEASURE: begin
        // A rise landing on the saturated count still reports that count.
        if (rise) begin
          period_out_d = period_cnt_q;
          high_out_d   = high_cnt_q;
          valid_d      = 1'b1;
          period_cnt_d = ONE;
          high_cnt_d   = ONE;
        end else if (period_cnt_q == SAT) begin
          state_d      = TIMEOUT;
          lost_d       = 1'b1;
          period_out_d = ZERO;
          high_out_d   = s2 ? SAT : ZERO;
          period_cnt_d = ZERO;
          high_cnt_d   = ZERO;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (s2) high_cnt_d = sat_inc(high_cnt_q);
        end
      end
      TIMEOUT: begin
        high_out_d   = s2 ? SAT : ZERO;
        period_cnt_d = ZERO;
        high_cnt_d   = ZERO;
        if (rise) begin
          state_d      = MEASURE;
          lost_d       = 1'b0;
          period_cnt_d = ONE;
          high_cnt_d   = ONE;
        end
      end
      default: state_d = WAIT_EDGE;
    endcase
  end

  assign high_out    = high_out_q;
  assign period_out  = period_out_q;
  assign valid       = valid_q;
  assign lost        = lost_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pwm_meas.sv
// Self-checking bench for pwm_meas: edge-distance reference model plus directed checks.
module tb_pwm_meas;
  import pwm_pkg::*;

  localparam int CW   = 7;
  localparam int MAXV = 127;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic          pwm_in;
  logic [CW-1:0] high_out, period_out;
  logic          valid, lost;
  pwm_state_e    dbg_state;

  always #5 clk = ~clk;

  pwm_meas #(.CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .high_out    (high_out),
    .period_out  (period_out),
    .valid       (valid),
    .lost        (lost),
    .dbg_state_o (dbg_state)
  );

  // scoreboard
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          lost_set_q[$];
  logic        lost_prev = 1'b0;

  // reference model: a valid is due 3 edges after each rise whose distance to the
  // previous armed rise is at most MAXV; it reports that distance and the prior high time
  bit have_rise = 1'b0;
  int last_rise = 0;
  int last_h    = 0;
  int t;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid === 1'b1) obs_q.push_back({cyc[17:0], period_out, high_out});
    if (lost === 1'b1 && lost_prev !== 1'b1) lost_set_q.push_back(cyc);
    lost_prev = lost;
  end

  function automatic logic [31:0] pack(input int stamp, input int per, input int hi);
    logic [31:0] r;
    r = {stamp[17:0], per[6:0], hi[6:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
    checks++;
    assert (obsv === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obsv, expv);
    end
  endtask

  // driver tasks
  task automatic rise_mark(input int h);
    if (have_rise && (cyc - last_rise) <= MAXV)
      exp_q.push_back(pack(cyc + 3, cyc - last_rise, last_h));
    have_rise = 1'b1;
    last_rise = cyc;
    last_h    = h;
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      pwm_in = v;
      @(negedge clk);
    end
  endtask

  task automatic drive_period(input int h, input int l);
    rise_mark(h);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic compare_valids(input string tag);
    logic [31:0] e, o;
    int n;
    repeat (4) @(negedge clk);
    chk({tag, "_valid_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_valid_cycle"}, {14'd0, o[31:14]}, {14'd0, e[31:14]});
      chk({tag, "_period_out"}, {25'd0, o[13:7]}, {25'd0, e[13:7]});
      chk({tag, "_high_out"}, {25'd0, o[6:0]}, {25'd0, e[6:0]});
      chk({tag, "_high_le_period"}, {31'd0, (o[6:0] <= o[13:7])}, 32'd1);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_high_out"}, {25'd0, high_out}, 32'd0);
    chk({tag, "_period_out"}, {25'd0, period_out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_lost"}, {31'd0, lost}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, {30'd0, WAIT_EDGE});
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // steady 64/10 waveform, then a duty sweep at period 64
    repeat (4) drive_period(10, 54);
    for (int d = 1; d <= 62; d++) drive_period(d, 64 - d);
    for (int d = 61; d >= 1; d--) drive_period(d, 64 - d);

    // input stuck low after lock
    rise_mark(20);
    hold(1'b1, 20);
    lost_set_q.delete();
    t = last_rise;
    hold(1'b0, 200);
    compare_valids("duty");
    chk("stuck_low_lost", {31'd0, lost}, 32'd1);
    chk("stuck_low_high_out", {25'd0, high_out}, 32'd0);
    chk("stuck_low_period_out", {25'd0, period_out}, 32'd0);
    chk("stuck_low_lost_events", lost_set_q.size(), 32'd1);
    if (lost_set_q.size() > 0) chk("stuck_low_lost_cycle", lost_set_q[0], t + 130);
    drive_period(10, 30);
    chk("recover_low_lost", {31'd0, lost}, 32'd0);
    drive_period(10, 30);
    compare_valids("recover_low");

    // input stuck high, then resume period 20 high 5
    lost_set_q.delete();
    rise_mark(200);
    t = last_rise;
    hold(1'b1, 200);
    chk("stuck_high_lost", {31'd0, lost}, 32'd1);
    chk("stuck_high_high_out", {25'd0, high_out}, 32'd127);
    chk("stuck_high_period_out", {25'd0, period_out}, 32'd0);
    if (lost_set_q.size() > 0) chk("stuck_high_lost_cycle", lost_set_q[0], t + 130);
    else chk("stuck_high_lost_events", lost_set_q.size(), 32'd1);
    hold(1'b0, 15);
    repeat (3) drive_period(5, 15);
    compare_valids("recover_high");
    chk("recover_high_lost", {31'd0, lost}, 32'd0);

    // rise exactly at saturation, then one cycle past it
    drive_period(60, 67);
    rise_mark(60);
    hold(1'b1, 5);
    chk("sat_rise_lost", {31'd0, lost}, 32'd0);
    hold(1'b1, 55);
    hold(1'b0, 68);
    drive_period(10, 20);
    drive_period(10, 20);
    compare_valids("boundary");

    // random periods, some long enough to time out
    repeat (25) drive_period($urandom_range(1, 60), $urandom_range(1, 75));
    drive_period(5, 5);
    compare_valids("random");

    // one-cycle reset in the middle of a period
    drive_period(10, 54);
    drive_period(10, 54);
    rise_mark(10);
    hold(1'b1, 10);
    hold(1'b0, 20);
    compare_valids("pre_reset");
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    have_rise = 1'b0;
    chk_outputs_zero("mid_reset");
    hold(1'b0, 5);
    repeat (3) drive_period(10, 30);
    compare_valids("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
